// File: rtl/cram_readback_ser.sv
// cram_readback_ser: reads len CRAM words through a synchronous read port,
// streams them MSB-first on a valid/ready bit interface and appends the
// CRC-16/CCITT (0x1021, non-reflected) of the transmitted data bits.
// All outputs are registered and are computed from the next-state values,
// so each output lines up exactly with the state it belongs to.
module cram_readback_ser #(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 8,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_bit,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_CRC   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // One bit-serial CRC-16/CCITT step.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb       = c[15] ^ b;
    crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] len_r, len_s;
  logic [ADDR_W-1:0] word_r, word_s;
  logic [5:0]        bit_cnt_r, bit_cnt_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [15:0]       crc_r, crc_s;
  logic [ADDR_W:0]   word_inc_s;

  logic              rd_en_s, tx_valid_s, tx_bit_s, busy_s, done_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Next-state and datapath update for the readback sequencer.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    word_s     = word_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    crc_s      = crc_r;
    word_inc_s = {1'b0, word_r} + {{ADDR_W{1'b0}}, 1'b1};
    case (state_r)
      S_IDLE: begin
        if (start) begin
          len_s  = len;
          word_s = '0;
          crc_s  = CRC_INIT;
          if (len != '0) begin
            state_s = S_REQ;
          end else begin
            state_s   = S_CRC;
            bit_cnt_s = 6'd16;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        shift_s   = rd_data;
        bit_cnt_s = 6'(DATA_W);
        state_s   = S_SHIFT;
      end
      S_SHIFT: begin
        if (tx_ready) begin
          shift_s   = shift_r << 1;
          crc_s     = crc_step(crc_r, shift_r[DATA_W-1]);
          bit_cnt_s = bit_cnt_r - 6'd1;
          if (bit_cnt_r == 6'd1) begin
            word_s = word_inc_s[ADDR_W-1:0];
            if (word_inc_s < {1'b0, len_r}) begin
              state_s = S_REQ;
            end else begin
              state_s   = S_CRC;
              bit_cnt_s = 6'd16;
            end
          end else begin
            state_s = S_SHIFT;
          end
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_CRC: begin
        if (tx_ready) begin
          // Trailer is shifted out as-is; it is not fed back into itself.
          crc_s     = {crc_r[14:0], 1'b0};
          bit_cnt_s = bit_cnt_r - 6'd1;
          if (bit_cnt_r == 6'd1) begin
            state_s = S_DONE;
          end else begin
            state_s = S_CRC;
          end
        end else begin
          state_s = S_CRC;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output values derived from the state being entered, registered below.
  always_comb begin
    rd_en_s    = (state_s == S_REQ);
    rd_addr_s  = rd_addr;
    tx_valid_s = 1'b0;
    tx_bit_s   = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    if (state_s == S_REQ) begin
      rd_addr_s = word_s;
    end else begin
      rd_addr_s = rd_addr;
    end
    case (state_s)
      S_REQ, S_WAIT: begin
        busy_s = 1'b1;
      end
      S_SHIFT: begin
        busy_s     = 1'b1;
        tx_valid_s = 1'b1;
        tx_bit_s   = shift_s[DATA_W-1];
      end
      S_CRC: begin
        busy_s     = 1'b1;
        tx_valid_s = 1'b1;
        tx_bit_s   = crc_s[15];
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      len_r     <= '0;
      word_r    <= '0;
      bit_cnt_r <= 6'd0;
      shift_r   <= '0;
      crc_r     <= CRC_INIT;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      tx_valid  <= 1'b0;
      tx_bit    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      len_r     <= len_s;
      word_r    <= word_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      crc_r     <= crc_s;
      rd_en     <= rd_en_s;
      rd_addr   <= rd_addr_s;
      tx_valid  <= tx_valid_s;
      tx_bit    <= tx_bit_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

endmodule

// File: tb/tb_cram_readback_ser.sv
// Self-checking bench for cram_readback_ser: a CRAM array with a one-cycle
// read latency, a bit-level reference model of the expected stream and CRC,
// and directed scenarios with randomized data and backpressure.
module tb_cram_readback_ser;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_bit;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [256];
  bit got_q [$];
  bit exp_q [$];
  bit ref_q [$];
  logic [15:0] got_trailer;

  cram_readback_ser #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_bit(tx_bit),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // CRAM model: synchronous read, data valid the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input longint obs, input longint exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected stream: words MSB-first, then CRC-16/CCITT of those bits.
  task automatic build_expected(input int n);
    logic [15:0] crc;
    logic [DATA_W-1:0] w;
    crc = 16'hFFFF;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w = mem[i];
      for (int b = DATA_W - 1; b >= 0; b--) begin
        exp_q.push_back(w[b]);
        if (crc[15] ^ w[b]) crc = (crc << 1) ^ 16'h1021;
        else                crc = crc << 1;
      end
    end
    for (int b = 15; b >= 0; b--) exp_q.push_back(crc[b]);
  endtask

  // Runs one readback; called at posedge+1 with the DUT idle.
  task automatic run_readback(input string tag, input int n, input bit bp, input int poke_cyc);
    int  cyc, rd_cnt, exp_addr, addr_bad, busy_bad, stall_bad, bubble_bad, mism, last_rd;
    bit  saw_done, prev_stall, prev_bit, prev_valid;
    build_expected(n);
    got_q.delete();
    rd_cnt = 0; exp_addr = 0; addr_bad = 0; busy_bad = 0; stall_bad = 0;
    bubble_bad = 0; saw_done = 0; prev_stall = 0; prev_bit = 0; prev_valid = 0; last_rd = -100;
    len = ADDR_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 0; cyc < 30000; cyc++) begin
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (cyc == poke_cyc);
      if (prev_stall && (tx_valid !== 1'b1 || tx_bit !== prev_bit)) stall_bad++;
      if (rd_en) begin
        if (rd_addr !== ADDR_W'(exp_addr)) addr_bad++;
        exp_addr++;
        rd_cnt++;
        last_rd = cyc;
      end
      if (n != 0 && tx_valid && !prev_valid && (cyc - last_rd) != 2) bubble_bad++;
      if (done) begin
        saw_done = 1;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (tx_valid && tx_ready) got_q.push_back(tx_bit);
      prev_stall = tx_valid && !tx_ready;
      prev_bit   = tx_bit;
      prev_valid = tx_valid;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, saw_done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_busy_during"}, busy_bad, 0);
    check({tag, "_rd_count"}, rd_cnt, n);
    check({tag, "_rd_addr_seq"}, addr_bad, 0);
    check({tag, "_bubble_timing"}, bubble_bad, 0);
    check({tag, "_stall_stable"}, stall_bad, 0);
    check({tag, "_bit_count"}, got_q.size(), n * DATA_W + 16);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_bit_stream"}, mism, 0);
    got_trailer = 16'h0000;
    if (got_q.size() >= 16)
      for (int i = 0; i < 16; i++) got_trailer[15 - i] = got_q[got_q.size() - 16 + i];
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {done, busy, tx_valid}, 0);
  endtask

  initial begin
    int  k, mism;
    bit  seen;
    rst = 1'b1; start = 1'b0; len = '0; tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rd_en, rd_addr, tx_valid, tx_bit, busy, done}, 0);

    // start coincident with rst: reset wins.
    start = 1'b1; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    check("start_with_rst", {busy, rd_en, tx_valid}, 0);
    @(posedge clk); #1;
    check("start_with_rst_idle", {busy, rd_en, tx_valid}, 0);

    // Golden CRC over "123456789".
    for (int i = 0; i < 9; i++) mem[i] = DATA_W'(8'h31 + i);
    run_readback("golden", 9, 0, -1);
    check("golden_trailer", got_trailer, 16'h29B1);

    // Empty readback: trailer only, equal to the seed.
    run_readback("empty", 0, 0, -1);
    check("empty_trailer", got_trailer, 16'hFFFF);

    // Backpressure: same stream with and without stalls.
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    run_readback("bp_ref", 2, 0, -1);
    ref_q = got_q;
    run_readback("bp_rand", 2, 1, -1);
    mism = (ref_q.size() != got_q.size()) ? 1 : 0;
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
      if (ref_q[i] !== got_q[i]) mism++;
    check("bp_same_stream", mism, 0);

    // Protocol timing with a start pulse mid-transfer.
    for (int i = 0; i < 3; i++) mem[i] = DATA_W'($urandom);
    run_readback("timing", 3, 0, 6);
    repeat (3) begin
      check("timing_stays_idle", {busy, rd_en, tx_valid}, 0);
      @(posedge clk); #1;
    end

    // Reset during the second word's SHIFT.
    for (int i = 0; i < 3; i++) mem[i] = DATA_W'($urandom);
    len = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (k = 0; k < 60 && !seen; k++) begin
      if (rd_en && rd_addr == 8'd1) seen = 1;
      @(posedge clk); #1;
    end
    check("rstmid_second_req", seen, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_in_shift", {tx_valid, busy}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_outputs", {rd_en, rd_addr, tx_valid, tx_bit, busy, done}, 0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      if (done || busy || tx_valid) seen = 1;
      @(posedge clk); #1;
    end
    check("rstmid_no_done", seen, 0);
    mem[0] = 8'h00;
    run_readback("after_rst", 1, 0, -1);

    // Maximum length with random data and random backpressure.
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
    run_readback("maxlen", 255, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
